// File: rtl/tbm_xfer_engine.sv
// Responder side of the ifq transfer handshake: moves one 4KB block word by word between xbuf and TBM.
// Optional ack watchdog enabled by defining TBM_XFER_TIMEOUT_EN.
module tbm_xfer_engine #(
  parameter int DATA_W      = 64,
  parameter int BLOCK_BYTES = 4096,
  parameter int XBUF_AW     = 9,
  parameter int TBM_AW      = 32,
  parameter int TIMEOUT     = 1023
) (
  input  logic                clock_fpga,
  input  logic                reset_n,
  input  logic                xfer_buf_select,
  input  logic                mwrite_enable,
  input  logic [31:0]         tbm_address,
  output logic                xfer_complete,
  output logic                xfer_error,
  output logic                xfer_busy,
  output logic                xbuf_rd_en,
  output logic [XBUF_AW-1:0]  xbuf_rd_addr,
  input  logic [DATA_W-1:0]   xbuf_rd_data,
  output logic                xbuf_wr_en,
  output logic [XBUF_AW-1:0]  xbuf_wr_addr,
  output logic [DATA_W-1:0]   xbuf_wr_data,
  output logic                tbm_req,
  output logic                tbm_we,
  output logic [TBM_AW-1:0]   tbm_addr,
  output logic [DATA_W-1:0]   tbm_wdata,
  input  logic                tbm_ack,
  input  logic [DATA_W-1:0]   tbm_rdata
);

  localparam int WORDS = BLOCK_BYTES / (DATA_W / 8);
  localparam int IDX_W = XBUF_AW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_FETCH,
    W_REQ,
    R_REQ,
    R_STORE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      block;
  logic             armed;
  logic             fetch_phase;
  logic             accept;
  logic             word_adv;
  logic             last_word;
  logic             timeout_hit;

  assign last_word    = (word_idx == LAST_IDX);
  assign xfer_busy    = (state != IDLE);
  assign xbuf_rd_addr = word_idx[XBUF_AW-1:0];
  assign xbuf_wr_addr = word_idx[XBUF_AW-1:0];
  // The block base is block*WORDS; WORDS is a power of two so this is a shift, truncated to TBM_AW.
  assign tbm_addr     = TBM_AW'({block, {XBUF_AW{1'b0}}}) + TBM_AW'(word_idx);

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    word_adv      = 1'b0;
    xbuf_rd_en    = 1'b0;
    xbuf_wr_en    = 1'b0;
    tbm_req       = 1'b0;
    tbm_we        = 1'b0;
    xfer_complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer_buf_select && armed) begin
          accept    = 1'b1;
          state_nxt = mwrite_enable ? W_FETCH : R_REQ;
        end
      end
      // First W_FETCH cycle issues the xbuf read; the second captures the returned word.
      W_FETCH: begin
        xbuf_rd_en = !fetch_phase;
        if (fetch_phase) begin
          state_nxt = W_REQ;
        end
      end
      W_REQ: begin
        tbm_req = 1'b1;
        tbm_we  = 1'b1;
        if (tbm_ack) begin
          if (last_word) begin
            state_nxt = DONE;
          end else begin
            word_adv  = 1'b1;
            state_nxt = W_FETCH;
          end
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      R_REQ: begin
        tbm_req = 1'b1;
        if (tbm_ack) begin
          state_nxt = R_STORE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      R_STORE: begin
        xbuf_wr_en = 1'b1;
        if (last_word) begin
          state_nxt = DONE;
        end else begin
          word_adv  = 1'b1;
          state_nxt = R_REQ;
        end
      end
      DONE: begin
        xfer_complete = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // armed stops a select that is still held after completion from starting another block.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      word_idx     <= '0;
      block        <= '0;
      armed        <= 1'b1;
      fetch_phase  <= 1'b0;
      tbm_wdata    <= '0;
      xbuf_wr_data <= '0;
    end else begin
      if (!xfer_buf_select) begin
        armed <= 1'b1;
      end else if (xfer_complete) begin
        armed <= 1'b0;
      end
      if (accept) begin
        block    <= tbm_address;
        word_idx <= '0;
      end else if (word_adv) begin
        word_idx <= word_idx + IDX_W'(1);
      end
      if (state == W_FETCH) begin
        fetch_phase <= !fetch_phase;
      end
      if (state == W_FETCH && fetch_phase) begin
        tbm_wdata <= xbuf_rd_data;
      end
      if (state == R_REQ && tbm_ack) begin
        xbuf_wr_data <= tbm_rdata;
      end
    end
  end

`ifdef TBM_XFER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign xfer_error  = xfer_complete && err_q;

  // Counts cycles of an unanswered request; the error flag is reported on the following DONE.
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!tbm_req || tbm_ack || timeout_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (tbm_req && !tbm_ack && timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign xfer_error  = 1'b0;
`endif

endmodule
